// File: rtl/core_ifu_pkg.sv
// core_ifu_pkg: shared constants, types and helpers for the instruction fetch unit.
//   CpuRstAddress     - fetch PC after reset (mirrors `CPURstAddress)
//   InstNop           - instruction shown when the buffer is empty (mirrors `INST_NOP)
//   IfuFifoDepth      - default buffer depth / max outstanding requests (`IFU_FIFO_DEPTH)
//   InstWordAlignMask - clears the byte-offset bits of an instruction address
//   ifu_entry_t       - one buffered {address, instruction} pair
// Optional feature macro used by core_ifu: IFU_ALIGN_CHECK_EN.
package core_ifu_pkg;

  localparam logic [31:0] CpuRstAddress     = 32'h0000_0000;
  localparam logic [31:0] InstNop           = 32'h0000_0013;
  localparam int unsigned IfuFifoDepth      = 4;
  localparam logic [31:0] InstWordAlignMask = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } ifu_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & InstWordAlignMask;
  endfunction

endpackage

// File: rtl/core_ifu_fifo.sv
// core_ifu_fifo: synchronous FIFO with asynchronous active-high reset and a flush.
//   clk, rst  - clock, async active-high reset (empties the FIFO)
//   i_flush   - synchronous empty; overrides push/pop in the same cycle
//   i_push    - write i_wdata at the tail (ignored when full without a pop)
//   i_pop     - drop the head entry (ignored when empty)
//   o_count   - number of valid entries
//   o_head    - head entry, valid whenever o_count != 0 (combinational read)
// DEPTH must be a power of two so the pointers wrap naturally.
module core_ifu_fifo
  import core_ifu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = IfuFifoDepth
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [WIDTH-1:0]             o_head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_do_pop;
  logic             w_do_push;
  logic [CW-1:0]    w_count_d;

  assign w_do_pop  = i_pop & (r_count != '0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

  always_comb begin
    w_count_d = r_count;
    if (i_flush) begin
      w_count_d = '0;
    end else if (w_do_push && !w_do_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_d = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_d;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/core_ifu.sv
// core_ifu: instruction fetch unit feeding the IF/ID pipeline register.
// Owns the fetch PC, issues requests on a pipelined req/gnt/rvalid instruction bus,
// buffers returned instructions in order and handles redirects and downstream hold.
//   clk, rst         - clock, async active-high reset
//   jump_en_i        - redirect fetch to jump_addr_i this cycle (highest priority)
//   jump_addr_i      - redirect target
//   hold_i           - downstream stall; head instruction is not consumed
//   ibus_req_o       - fetch request valid; ibus_addr_o is the word-aligned fetch PC
//   ibus_gnt_i       - request accepted this cycle
//   ibus_rvalid_i    - in-order response valid, ibus_rdata_i its instruction
//   inst_valid_o     - head instruction valid; inst_addr_o / inst_o are the head pair
//   fetch_misalign_o - only with IFU_ALIGN_CHECK_EN: a misaligned jump parked fetch
// Without IFU_ALIGN_CHECK_EN the low two target bits are silently cleared.
module core_ifu
  import core_ifu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = IfuFifoDepth
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_discard;

  logic [31:0]   w_pc_d;
  logic [CW-1:0] w_discard_d;
  logic [CW-1:0] w_outstanding;
  logic [CW-1:0] w_fifo_count;
  ifu_entry_t    w_head;
  ifu_entry_t    w_push_entry;
  logic [31:0]   w_pend_addr;
  logic          w_fifo_nonempty;
  logic          w_pop;
  logic          w_grant;
  logic          w_data_push;
  logic [CW:0]   w_credit_used;
  logic          w_credit_ok;
  logic          w_parked;

`ifdef IFU_ALIGN_CHECK_EN
  logic        r_misalign;
  logic [31:0] r_bad_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
      r_bad_addr <= CpuRstAddress;
    end else if (jump_en_i) begin
      r_misalign <= |jump_addr_i[1:0];
      r_bad_addr <= jump_addr_i;
    end
  end

  assign w_parked         = r_misalign;
  assign fetch_misalign_o = r_misalign;
`else
  assign w_parked = 1'b0;
`endif

  // The pending-address queue holds exactly the in-flight requests, so its
  // occupancy is the outstanding count.
  core_ifu_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_pend_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (1'b0),
    .i_push  (w_grant),
    .i_wdata (r_pc),
    .i_pop   (ibus_rvalid_i),
    .o_count (w_outstanding),
    .o_head  (w_pend_addr)
  );

  assign w_push_entry = '{addr: w_pend_addr, inst: ibus_rdata_i};

  core_ifu_fifo #(
    .WIDTH ($bits(ifu_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_data_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (jump_en_i),
    .i_push  (w_data_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_count (w_fifo_count),
    .o_head  (w_head)
  );

  assign w_fifo_nonempty = (w_fifo_count != '0);
  assign inst_valid_o    = w_fifo_nonempty & ~jump_en_i;
  assign w_pop           = inst_valid_o & ~hold_i;

  // Credit covers buffered entries plus every in-flight slot, including ones
  // that will be discarded, so a response always finds room in the buffer.
  assign w_credit_used = {1'b0, w_outstanding} + {1'b0, w_fifo_count} - {{CW{1'b0}}, w_pop};
  assign w_credit_ok   = (w_credit_used < CW1'(FIFO_DEPTH));

  assign ibus_req_o  = ~rst & ~jump_en_i & ~w_parked & w_credit_ok;
  assign ibus_addr_o = r_pc;
  assign w_grant     = ibus_req_o & ibus_gnt_i;

  // Responses are dropped while stale ones drain, and on the redirect cycle itself.
  assign w_data_push = ibus_rvalid_i & ~jump_en_i & (r_discard == '0);

  always_comb begin
    w_pc_d = r_pc;
    if (jump_en_i) begin
      w_pc_d = align_word(jump_addr_i);
    end else if (w_grant) begin
      w_pc_d = r_pc + 32'd4;
    end
  end

  always_comb begin
    w_discard_d = r_discard;
    if (jump_en_i) begin
      w_discard_d = w_outstanding -
                    ((ibus_rvalid_i && (w_outstanding != '0)) ? CW'(1) : '0);
    end else if (ibus_rvalid_i && (r_discard != '0)) begin
      w_discard_d = r_discard - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= CpuRstAddress;
      r_discard <= '0;
    end else begin
      r_pc      <= w_pc_d;
      r_discard <= w_discard_d;
    end
  end

  always_comb begin
    inst_addr_o = w_fifo_nonempty ? w_head.addr : r_pc;
    inst_o      = w_fifo_nonempty ? w_head.inst : InstNop;
`ifdef IFU_ALIGN_CHECK_EN
    if (r_misalign) inst_addr_o = r_bad_addr;
`endif
  end

endmodule

// File: tb/tb_core_ifu.sv
module tb_core_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [31:0] inst;
`ifdef IFU_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  bit          resp_en;
  logic [31:0] bus_q[$];
  logic [31:0] cons_addr[$];
  logic [31:0] cons_inst[$];

  localparam logic [31:0] Nop = 32'h0000_0013;

  core_ifu #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .jump_en_i        (jump_en),
    .jump_addr_i      (jump_addr),
    .hold_i           (hold),
    .ibus_req_o       (ibus_req),
    .ibus_addr_o      (ibus_addr),
    .ibus_gnt_i       (ibus_gnt),
    .ibus_rvalid_i    (ibus_rvalid),
    .ibus_rdata_i     (ibus_rdata),
    .inst_valid_o     (inst_valid),
    .inst_addr_o      (inst_addr),
    .inst_o           (inst)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .fetch_misalign_o (misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: each word encodes its own address so order errors are visible.
  function automatic logic [31:0] mk_inst(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // Bus model: grants are captured mid-cycle, answered in order one cycle later.
  always @(negedge clk) begin
    if (ibus_req && ibus_gnt) bus_q.push_back(ibus_addr);
    if (!rst && inst_valid && !hold) begin
      cons_addr.push_back(inst_addr);
      cons_inst.push_back(inst);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus_q.delete();
      ibus_rvalid = 1'b0;
      ibus_rdata  = 32'h0;
    end else if (resp_en && bus_q.size() > 0) begin
      ibus_rvalid = 1'b1;
      ibus_rdata  = mk_inst(bus_q.pop_front());
    end else begin
      ibus_rvalid = 1'b0;
      ibus_rdata  = 32'h0;
    end
  end

  task automatic to_cycle_start();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    to_cycle_start();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    cons_addr.delete();
    cons_inst.delete();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ibus_req !== 1'b0) begin errors++;
      $display("FAIL reset_req got %b want 0", ibus_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++; if (inst_addr !== 32'h0) begin errors++;
      $display("FAIL reset_addr got %h want 00000000", inst_addr); end
    checks++; if (inst !== Nop) begin errors++;
      $display("FAIL reset_inst got %h want %h", inst, Nop); end
    to_cycle_start();
    rst = 1'b0;
  endtask

  // Cycle k after reset: request 4k, head 4(k-2) from cycle 2 on; pc shown while empty.
  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_addr = (k < 2) ? 32'(4 * k) : 32'(4 * (k - 2));
      exp_inst = (k < 2) ? Nop : mk_inst(exp_addr);
      checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'(4 * k)) begin errors++;
        $display("FAIL stream_req cyc%0d got %b/%h want 1/%h", k, ibus_req, ibus_addr, 4 * k); end
      checks++; if (inst_valid !== (k >= 2)) begin errors++;
        $display("FAIL stream_valid cyc%0d got %b want %b", k, inst_valid, k >= 2); end
      checks++; if (inst_addr !== exp_addr || inst !== exp_inst) begin errors++;
        $display("FAIL stream_head cyc%0d got %h/%h want %h/%h", k, inst_addr, inst,
                 exp_addr, exp_inst); end
    end
  endtask

  // Hold from cycle 8: head 24 sticks, two more requests (32, 36) then credit runs out.
  task automatic test_hold();
    for (int i = 0; i < 6; i++) begin
      to_cycle_start();
      hold = 1'b1;
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'd24 || inst !== mk_inst(32'd24))
        begin errors++;
        $display("FAIL hold_head i%0d got %b/%h/%h want 1/00000018/%h", i, inst_valid,
                 inst_addr, inst, mk_inst(32'd24)); end
      checks++; if (ibus_req !== (i < 2)) begin errors++;
        $display("FAIL hold_req i%0d got %b want %b", i, ibus_req, i < 2); end
      if (i < 2) begin
        checks++; if (ibus_addr !== 32'(32 + 4 * i)) begin errors++;
          $display("FAIL hold_addr i%0d got %h want %h", i, ibus_addr, 32 + 4 * i); end
      end
    end
    to_cycle_start();
    hold = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    checks++; if (cons_addr.size() != 16) begin errors++;
      $display("FAIL hold_consumed_count got %0d want 16", cons_addr.size()); end
    for (int i = 0; i < cons_addr.size() && i < 16; i++) begin
      checks++; if (cons_addr[i] !== 32'(4 * i) || cons_inst[i] !== mk_inst(32'(4 * i)))
        begin errors++;
        $display("FAIL hold_order idx%0d got %h/%h want %h/%h", i, cons_addr[i], cons_inst[i],
                 4 * i, mk_inst(32'(4 * i))); end
    end
  endtask

  task automatic test_reset_midstream();
    to_cycle_start();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ibus_req !== 1'b0 || inst_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_ctrl got req %b valid %b want 0/0", ibus_req, inst_valid); end
    checks++; if (inst_addr !== 32'h0 || inst !== Nop) begin errors++;
      $display("FAIL midrst_head got %h/%h want 00000000/%h", inst_addr, inst, Nop); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_restart got %b/%h/%b want 1/00000000/0", ibus_req, ibus_addr,
               inst_valid); end
  endtask

  // Requests 0 and 4 in flight when jumping to 0x100: both responses must be dropped.
  task automatic test_jump_discard();
    resp_en  = 1'b0;
    ibus_gnt = 1'b1;
    apply_reset();
    to_cycle_start();
    to_cycle_start();
    ibus_gnt  = 1'b0;
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0100;
    @(negedge clk);
    checks++; if (ibus_req !== 1'b0 || inst_valid !== 1'b0) begin errors++;
      $display("FAIL jd_jumpcyc got %b/%b want 0/0", ibus_req, inst_valid); end
    resp_en = 1'b1;
    to_cycle_start();
    jump_en  = 1'b0;
    ibus_gnt = 1'b1;
    @(negedge clk);
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h100 || inst_valid !== 1'b0 ||
                  inst_addr !== 32'h100 || inst !== Nop) begin errors++;
      $display("FAIL jd_cyc3 got %b/%h/%b/%h/%h want 1/00000100/0/00000100/%h", ibus_req,
               ibus_addr, inst_valid, inst_addr, inst, Nop); end
    @(negedge clk);
    checks++; if (ibus_addr !== 32'h104 || inst_valid !== 1'b0 || inst_addr !== 32'h104) begin
      errors++;
      $display("FAIL jd_cyc4 got %h/%b/%h want 00000104/0/00000104", ibus_addr, inst_valid,
               inst_addr); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++;
      $display("FAIL jd_cyc5 valid got %b want 0", inst_valid); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h100 || inst !== mk_inst(32'h100))
      begin errors++;
      $display("FAIL jd_first got %b/%h/%h want 1/00000100/%h", inst_valid, inst_addr, inst,
               mk_inst(32'h100)); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h104) begin errors++;
      $display("FAIL jd_second got %b/%h want 1/00000104", inst_valid, inst_addr); end
  endtask

  // Cycle 4: head 8 would pop and the response for 12 arrives; the jump drops both.
  task automatic test_jump_rvalid_pop();
    resp_en  = 1'b1;
    ibus_gnt = 1'b1;
    apply_reset();
    repeat (4) to_cycle_start();
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0200;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || ibus_req !== 1'b0) begin errors++;
      $display("FAIL jr_jumpcyc got %b/%b want 0/0", inst_valid, ibus_req); end
    to_cycle_start();
    jump_en = 1'b0;
    @(negedge clk);
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h200 || inst_valid !== 1'b0 ||
                  inst_addr !== 32'h200) begin errors++;
      $display("FAIL jr_cyc5 got %b/%h/%b/%h want 1/00000200/0/00000200", ibus_req, ibus_addr,
               inst_valid, inst_addr); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++;
      $display("FAIL jr_cyc6 valid got %b want 0", inst_valid); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h200 || inst !== mk_inst(32'h200))
      begin errors++;
      $display("FAIL jr_first got %b/%h/%h want 1/00000200/%h", inst_valid, inst_addr, inst,
               mk_inst(32'h200)); end
    @(posedge clk);
    #2;
    checks++; if (cons_addr.size() != 3) begin errors++;
      $display("FAIL jr_consumed_count got %0d want 3", cons_addr.size()); end
  endtask

  task automatic test_gnt_stall();
    resp_en  = 1'b1;
    ibus_gnt = 1'b0;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_cyc%0d got %b/%h/%b want 1/00000000/0", c, ibus_req, ibus_addr,
                 inst_valid); end
      to_cycle_start();
    end
    ibus_gnt = 1'b1;
    @(negedge clk);
    checks++; if (ibus_addr !== 32'h0) begin errors++;
      $display("FAIL stall_resume0 got %h want 00000000", ibus_addr); end
    @(negedge clk);
    checks++; if (ibus_addr !== 32'h4 || inst_valid !== 1'b0) begin errors++;
      $display("FAIL stall_resume1 got %h/%b want 00000004/0", ibus_addr, inst_valid); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst !== mk_inst(32'h0)) begin
      errors++;
      $display("FAIL stall_first got %b/%h/%h want 1/00000000/%h", inst_valid, inst_addr, inst,
               mk_inst(32'h0)); end
  endtask

  task automatic test_align();
    resp_en  = 1'b1;
    ibus_gnt = 1'b1;
    apply_reset();
    repeat (3) to_cycle_start();
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0102;
    to_cycle_start();
    jump_en = 1'b0;
    @(negedge clk);
`ifdef IFU_ALIGN_CHECK_EN
    checks++; if (misalign !== 1'b1 || ibus_req !== 1'b0 || inst_valid !== 1'b0 ||
                  inst_addr !== 32'h102) begin errors++;
      $display("FAIL align_park got %b/%b/%b/%h want 1/0/0/00000102", misalign, ibus_req,
               inst_valid, inst_addr); end
    to_cycle_start();
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0200;
    @(negedge clk);
    checks++; if (misalign !== 1'b1 || ibus_req !== 1'b0) begin errors++;
      $display("FAIL align_jumpcyc got %b/%b want 1/0", misalign, ibus_req); end
    to_cycle_start();
    jump_en = 1'b0;
    @(negedge clk);
    checks++; if (misalign !== 1'b0 || ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin
      errors++;
      $display("FAIL align_clear got %b/%b/%h want 0/1/00000200", misalign, ibus_req,
               ibus_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h200) begin errors++;
      $display("FAIL align_resume got %b/%h want 1/00000200", inst_valid, inst_addr); end
`else
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h100 || inst_addr !== 32'h100 ||
                  inst_valid !== 1'b0) begin errors++;
      $display("FAIL align_force got %b/%h/%h/%b want 1/00000100/00000100/0", ibus_req,
               ibus_addr, inst_addr, inst_valid); end
    @(negedge clk);
    checks++; if (ibus_addr !== 32'h104) begin errors++;
      $display("FAIL align_next got %h want 00000104", ibus_addr); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h100 || inst !== mk_inst(32'h100))
      begin errors++;
      $display("FAIL align_first got %b/%h/%h want 1/00000100/%h", inst_valid, inst_addr, inst,
               mk_inst(32'h100)); end
`endif
  endtask

  initial begin
    rst         = 1'b1;
    jump_en     = 1'b0;
    jump_addr   = 32'h0;
    hold        = 1'b0;
    ibus_gnt    = 1'b1;
    ibus_rvalid = 1'b0;
    ibus_rdata  = 32'h0;
    resp_en     = 1'b1;
    test_reset();
    test_stream();
    test_hold();
    test_reset_midstream();
    test_jump_discard();
    test_jump_rvalid_pop();
    test_gnt_stall();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
